sw_debounce: RTL and testbench
==============================

// Module: sw_debounce
// PURPOSE
//  Per-channel synchroniser and debouncer for raw slide-switch / push-button pins on the DECA board.
//  Sits directly upstream of the switch PIO: sw_db drives the PIO in_port, so the PIO edge-capture
//  logic sees exactly one clean edge per physical actuation.
//  Also emits one-cycle rise/fall strobes for fabric logic that bypasses the Nios.
// PARAMETERS
//  WIDTH            2        number of independent switch channels
//  SYNC_STAGES      2        flip-flops in the metastability synchroniser chain (>=2)
//  DEBOUNCE_CYCLES  500000   consecutive clk cycles of stable mismatch needed to accept a change (>=1; 10 ms @ 50 MHz)
//  RESET_LEVEL      1'b0     value loaded into the synchroniser and sw_db on reset (all channels)
// PORTS
//  clk          in   1      system clock
//  reset_n      in   1      asynchronous, active-low reset
//  sw_raw       in   WIDTH  raw asynchronous pad inputs
//  sw_db        out  WIDTH  debounced, synchronised level (to PIO in_port)
//  rise_pulse   out  WIDTH  1-cycle strobe coincident with sw_db[i] going 0->1
//  fall_pulse   out  WIDTH  1-cycle strobe coincident with sw_db[i] going 1->0
//  stable       out  1      high when no channel has a pending, unaccepted change (all counters 0)
// BEHAVIOUR
//  - Reset (reset_n low, async): sync chain = RESET_LEVEL; sw_db = {WIDTH{RESET_LEVEL}}; counters = 0;
//    rise_pulse = fall_pulse = 0; stable = 1. Counting restarts from 0 after release.
//  - All outputs registered; no combinational path from sw_raw to any output.
//  - Sync: sw_sync[i] = sw_raw[i] delayed by SYNC_STAGES clk edges.
//  - Per channel, two implicit states via counter cnt (width $clog2(DEBOUNCE_CYCLES+1)):
//    IDLE (cnt==0, sw_sync==sw_db):
//      stay in IDLE.
//    COUNT (sw_sync!=sw_db):
//      cnt increments each cycle of mismatch.
//    - On the cycle the DEBOUNCE_CYCLES-th consecutive mismatch is sampled:
//      sw_db<=sw_sync; cnt<=0; the matching pulse<=1 for that one cycle.
//    - Any cycle with sw_sync==sw_db (bounce back): cnt<=0 immediately, no output change.
//  - Latency: a clean step on sw_raw appears on sw_db exactly SYNC_STAGES+DEBOUNCE_CYCLES clk edges later.
//  - Any glitch shorter than DEBOUNCE_CYCLES synchronised cycles is fully rejected.
//  - DEBOUNCE_CYCLES==1: block degenerates to a pure synchroniser plus 1-cycle register.
//  - Counter never exceeds DEBOUNCE_CYCLES-1; no wrap possible.
//  - Pulses are deasserted on the cycle after assertion.
//  - rise_pulse[i] and fall_pulse[i] are never high together.
//  - Channels are fully independent: simultaneous changes on several channels update in the same cycle.
//  - stable = ~|{cnt[i]!=0}; it is registered alongside the counters.
// STRUCTURE
//  - Shared package deca_io_pkg: DECA_CLK_HZ (50_000_000) and the default DEBOUNCE_CYCLES constant,
//    reused by the button/switch top-level instances.
//  - No typedefs required; counter width is a local parameter.
//  - Sub-module sw_debounce_chan holds the single-channel sync chain, counter, sw_db bit and pulse regs.
//    The top instantiates it WIDTH times in a generate loop and reduces stable.
// TESTING  (WIDTH=2, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, RESET_LEVEL=0 unless stated)
//  1 Reset with sw_raw=2'b11 held -> sw_db=00, pulses=00, stable=1 during reset;
//    after release sw_db=11 exactly 10 edges later.
//  2 Clean press ch0 0->1 held -> sw_db[0]=1 exactly 10 edges after the step;
//    rise_pulse[0] high 1 cycle; fall_pulse=00; sw_db[1] unchanged.
//  3 Bounce ch0 toggling every 3 cycles for 30 cycles, then held 1 -> no sw_db/pulse activity while bouncing;
//    sw_db[0] rises 10 edges after the last edge.
//  4 Glitch ch0 high for 7 cycles -> sw_db[0] stays 0, stable returns to 1;
//    the same glitch for 8 cycles -> sw_db[0]=1 plus a rise pulse.
//  5 From sw_db=10, apply ch0 0->1 and ch1 1->0 on the same edge -> both bits flip on the same cycle;
//    rise_pulse=01, fall_pulse=10.
//  6 Drop reset_n mid-count (cnt=5) with sw_raw[0]=1 -> immediate reset values;
//    after release a full 10 edges are required before sw_db[0]=1.
//    Repeat with RESET_LEVEL=1 and expect inverted reset values.

Source files
------------

// File: rtl/deca_io_pkg.sv
// Board-level constants shared by the DECA button/switch input instances.
package deca_io_pkg;

  localparam int DECA_CLK_HZ = 50_000_000;

  // 10 ms of stable input at the board clock before a new level is accepted
  localparam int DEBOUNCE_CYCLES_DEFAULT = DECA_CLK_HZ / 100;

endpackage

// File: rtl/sw_debounce_chan.sv
// One switch channel: synchroniser chain, mismatch counter, debounced level and edge strobes.
module sw_debounce_chan
  import deca_io_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  output logic sw_db,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic pending
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sw_sync;
  logic [CNT_W-1:0]       cnt;
  logic [CNT_W-1:0]       cnt_next;
  logic                   accept;

  assign sw_sync = sync_q[SYNC_STAGES-1];

  // Any matching cycle clears the count; the last mismatch accepts the new level instead of counting on.
  always_comb begin
    accept   = 1'b0;
    cnt_next = '0;
    if (sw_sync != sw_db) begin
      if (cnt == CNT_LAST) begin
        accept = 1'b1;
      end else begin
        cnt_next = cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= {SYNC_STAGES{RESET_LEVEL}};
      sw_db      <= RESET_LEVEL;
      cnt        <= '0;
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
      pending    <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], sw_raw};
      cnt        <= cnt_next;
      pending    <= (cnt_next != '0);
      rise_pulse <= accept & sw_sync;
      fall_pulse <= accept & ~sw_sync;
      if (accept) begin
        sw_db <= sw_sync;
      end
    end
  end

endmodule

// File: rtl/sw_debounce.sv
// Multi-channel switch debouncer feeding the switch PIO, plus rise/fall strobes for fabric logic.
module sw_debounce
  import deca_io_pkg::*;
#(
  parameter int   WIDTH           = 2,
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_db,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             stable
);

  logic [WIDTH-1:0] pending;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chan
    sw_debounce_chan #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_chan (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw_raw    (sw_raw[i]),
      .sw_db     (sw_db[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i]),
      .pending   (pending[i])
    );
  end

  // Each pending bit is a register, so stable carries no path back to sw_raw.
  assign stable = ~|pending;

endmodule

// File: tb/tb_sw_debounce.sv
// Scoreboard bench for sw_debounce: expectations are queued per edge when stimulus is planned.
module tb_sw_debounce;

  localparam logic [6:0] ALL   = 7'b1111111;
  localparam logic [6:0] NOSTB = 7'b1111110;

  typedef struct {
    string      name;
    int         due;
    bit         sel;
    logic [6:0] exp;
    logic [6:0] mask;
  } chk_t;

  logic       clk = 1'b0;
  logic       reset_n, reset_n1;
  logic [1:0] sw_raw, sw_raw1;
  logic [1:0] sw_db, rise_pulse, fall_pulse;
  logic [1:0] sw_db1, rise_pulse1, fall_pulse1;
  logic       stable, stable1;
  logic [6:0] obs0, obs1;

  int   edges = 0;
  int   total = 0;
  int   bad   = 0;
  chk_t sb[$];

  sw_debounce #(.WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .RESET_LEVEL(1'b0)) dut (
    .clk(clk), .reset_n(reset_n), .sw_raw(sw_raw), .sw_db(sw_db),
    .rise_pulse(rise_pulse), .fall_pulse(fall_pulse), .stable(stable)
  );

  sw_debounce #(.WIDTH(2), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .RESET_LEVEL(1'b1)) dut1 (
    .clk(clk), .reset_n(reset_n1), .sw_raw(sw_raw1), .sw_db(sw_db1),
    .rise_pulse(rise_pulse1), .fall_pulse(fall_pulse1), .stable(stable1)
  );

  assign obs0 = {sw_db, rise_pulse, fall_pulse, stable};
  assign obs1 = {sw_db1, rise_pulse1, fall_pulse1, stable1};

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  function automatic logic [6:0] mk(input logic [1:0] db, input logic [1:0] r,
                                    input logic [1:0] f, input logic st);
    return {db, r, f, st};
  endfunction

  function automatic void want(input string name, input int due, input bit sel,
                               input logic [6:0] exp, input logic [6:0] mask);
    chk_t e;
    e.name = name; e.due = due; e.sel = sel; e.exp = exp; e.mask = mask;
    sb.push_back(e);
  endfunction

  task automatic reset_dut(input logic [1:0] raw);
    sw_raw  = raw;
    reset_n = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    chk_t e; logic [6:0] obs; int base;
    base = edges;
    want("rst_async", base + 0, 0, mk(2'b00, 2'b00, 2'b00, 1'b1), ALL);
    want("rst_held", base + 2, 0, mk(2'b00, 2'b00, 2'b00, 1'b1), ALL);
    want("rst_rel_early", base + 12, 0, mk(2'b00, 2'b00, 2'b00, 1'b0), ALL);
    want("rst_rel_accept", base + 13, 0, mk(2'b11, 2'b11, 2'b00, 1'b1), ALL);
    want("rst_rel_after", base + 14, 0, mk(2'b11, 2'b00, 2'b00, 1'b1), ALL);
    for (int c = 0; c <= 14; c++) begin
      if (c == 0) begin sw_raw = 2'b11; reset_n = 1'b0; end
      if (c == 3) reset_n = 1'b1;
      #1;
      while (sb.size() > 0 && sb[0].due == edges) begin
        e = sb.pop_front(); obs = e.sel ? obs1 : obs0; total++;
        if ((obs & e.mask) !== (e.exp & e.mask)) begin
          bad++;
          $display("[TB] FAIL %s edge %0d: saw %b need %b", e.name, edges, obs & e.mask, e.exp & e.mask);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_clean_press();
    chk_t e; logic [6:0] obs; int base;
    reset_dut(2'b00);
    base = edges;
    want("press_early", base + 9, 0, mk(2'b00, 2'b00, 2'b00, 1'b0), ALL);
    want("press_accept", base + 10, 0, mk(2'b01, 2'b01, 2'b00, 1'b1), ALL);
    want("press_after", base + 11, 0, mk(2'b01, 2'b00, 2'b00, 1'b1), ALL);
    for (int c = 0; c <= 11; c++) begin
      if (c == 0) sw_raw = 2'b01;
      #1;
      while (sb.size() > 0 && sb[0].due == edges) begin
        e = sb.pop_front(); obs = e.sel ? obs1 : obs0; total++;
        if ((obs & e.mask) !== (e.exp & e.mask)) begin
          bad++;
          $display("[TB] FAIL %s edge %0d: saw %b need %b", e.name, edges, obs & e.mask, e.exp & e.mask);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_bounce();
    chk_t e; logic [6:0] obs; int base;
    reset_dut(2'b00);
    base = edges;
    for (int k = 1; k <= 39; k++) want("bounce_quiet", base + k, 0, mk(2'b00, 2'b00, 2'b00, 1'b0), NOSTB);
    want("bounce_accept", base + 40, 0, mk(2'b01, 2'b01, 2'b00, 1'b1), ALL);
    want("bounce_after", base + 41, 0, mk(2'b01, 2'b00, 2'b00, 1'b1), ALL);
    for (int c = 0; c <= 41; c++) begin
      sw_raw[0] = (c < 30) ? (((c / 3) % 2) == 0) : 1'b1;
      #1;
      while (sb.size() > 0 && sb[0].due == edges) begin
        e = sb.pop_front(); obs = e.sel ? obs1 : obs0; total++;
        if ((obs & e.mask) !== (e.exp & e.mask)) begin
          bad++;
          $display("[TB] FAIL %s edge %0d: saw %b need %b", e.name, edges, obs & e.mask, e.exp & e.mask);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_glitch();
    chk_t e; logic [6:0] obs; int base;
    reset_dut(2'b00);
    base = edges;
    for (int k = 1; k <= 8; k++) want("glitch7_quiet", base + k, 0, mk(2'b00, 2'b00, 2'b00, 1'b0), NOSTB);
    want("glitch7_peak", base + 9, 0, mk(2'b00, 2'b00, 2'b00, 1'b0), ALL);
    want("glitch7_clear", base + 10, 0, mk(2'b00, 2'b00, 2'b00, 1'b1), ALL);
    want("glitch7_hold", base + 12, 0, mk(2'b00, 2'b00, 2'b00, 1'b1), ALL);
    want("glitch8_early", base + 22, 0, mk(2'b00, 2'b00, 2'b00, 1'b0), ALL);
    want("glitch8_accept", base + 23, 0, mk(2'b01, 2'b01, 2'b00, 1'b1), ALL);
    want("glitch8_after", base + 24, 0, mk(2'b01, 2'b00, 2'b00, 1'b0), ALL);
    want("glitch8_fall", base + 31, 0, mk(2'b00, 2'b00, 2'b01, 1'b1), ALL);
    want("glitch8_idle", base + 32, 0, mk(2'b00, 2'b00, 2'b00, 1'b1), ALL);
    for (int c = 0; c <= 32; c++) begin
      sw_raw[0] = (c < 7) || (c >= 13 && c < 21);
      #1;
      while (sb.size() > 0 && sb[0].due == edges) begin
        e = sb.pop_front(); obs = e.sel ? obs1 : obs0; total++;
        if ((obs & e.mask) !== (e.exp & e.mask)) begin
          bad++;
          $display("[TB] FAIL %s edge %0d: saw %b need %b", e.name, edges, obs & e.mask, e.exp & e.mask);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    chk_t e; logic [6:0] obs; int base;
    reset_dut(2'b00);
    base = edges;
    want("b2b_setup", base + 10, 0, mk(2'b10, 2'b10, 2'b00, 1'b1), ALL);
    want("b2b_setup_after", base + 11, 0, mk(2'b10, 2'b00, 2'b00, 1'b1), ALL);
    want("b2b_early", base + 21, 0, mk(2'b10, 2'b00, 2'b00, 1'b0), ALL);
    want("b2b_swap", base + 22, 0, mk(2'b01, 2'b01, 2'b10, 1'b1), ALL);
    want("b2b_after", base + 23, 0, mk(2'b01, 2'b00, 2'b00, 1'b1), ALL);
    for (int c = 0; c <= 23; c++) begin
      if (c == 0) sw_raw = 2'b10;
      if (c == 12) sw_raw = 2'b01;
      #1;
      while (sb.size() > 0 && sb[0].due == edges) begin
        e = sb.pop_front(); obs = e.sel ? obs1 : obs0; total++;
        if ((obs & e.mask) !== (e.exp & e.mask)) begin
          bad++;
          $display("[TB] FAIL %s edge %0d: saw %b need %b", e.name, edges, obs & e.mask, e.exp & e.mask);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_mid_count();
    chk_t e; logic [6:0] obs; int base;
    reset_dut(2'b00);
    base = edges;
    want("mid_counting", base + 6, 0, mk(2'b00, 2'b00, 2'b00, 1'b0), ALL);
    want("mid_async_rst", base + 7, 0, mk(2'b00, 2'b00, 2'b00, 1'b1), ALL);
    want("mid_held_rst", base + 8, 0, mk(2'b00, 2'b00, 2'b00, 1'b1), ALL);
    want("mid_rel_early", base + 18, 0, mk(2'b00, 2'b00, 2'b00, 1'b0), ALL);
    want("mid_rel_accept", base + 19, 0, mk(2'b01, 2'b01, 2'b00, 1'b1), ALL);
    want("mid_rel_after", base + 20, 0, mk(2'b01, 2'b00, 2'b00, 1'b1), ALL);
    for (int c = 0; c <= 20; c++) begin
      if (c == 0) sw_raw = 2'b01;
      if (c == 7) reset_n = 1'b0;
      if (c == 9) reset_n = 1'b1;
      #1;
      while (sb.size() > 0 && sb[0].due == edges) begin
        e = sb.pop_front(); obs = e.sel ? obs1 : obs0; total++;
        if ((obs & e.mask) !== (e.exp & e.mask)) begin
          bad++;
          $display("[TB] FAIL %s edge %0d: saw %b need %b", e.name, edges, obs & e.mask, e.exp & e.mask);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_level_one();
    chk_t e; logic [6:0] obs; int base;
    base = edges;
    want("lvl1_rst_state", base + 0, 1, mk(2'b11, 2'b00, 2'b00, 1'b1), ALL);
    want("lvl1_counting", base + 7, 1, mk(2'b11, 2'b00, 2'b00, 1'b0), ALL);
    want("lvl1_async_rst", base + 8, 1, mk(2'b11, 2'b00, 2'b00, 1'b1), ALL);
    want("lvl1_held_rst", base + 9, 1, mk(2'b11, 2'b00, 2'b00, 1'b1), ALL);
    want("lvl1_rel_early", base + 19, 1, mk(2'b11, 2'b00, 2'b00, 1'b0), ALL);
    want("lvl1_rel_accept", base + 20, 1, mk(2'b10, 2'b00, 2'b01, 1'b1), ALL);
    want("lvl1_rel_after", base + 21, 1, mk(2'b10, 2'b00, 2'b00, 1'b1), ALL);
    for (int c = 0; c <= 21; c++) begin
      if (c == 0) begin sw_raw1 = 2'b11; reset_n1 = 1'b1; end
      if (c == 1) sw_raw1 = 2'b10;
      if (c == 8) reset_n1 = 1'b0;
      if (c == 10) reset_n1 = 1'b1;
      #1;
      while (sb.size() > 0 && sb[0].due == edges) begin
        e = sb.pop_front(); obs = e.sel ? obs1 : obs0; total++;
        if ((obs & e.mask) !== (e.exp & e.mask)) begin
          bad++;
          $display("[TB] FAIL %s edge %0d: saw %b need %b", e.name, edges, obs & e.mask, e.exp & e.mask);
        end
      end
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset_n  = 1'b1;
    sw_raw   = 2'b00;
    reset_n1 = 1'b0;
    sw_raw1  = 2'b11;
    @(posedge clk); #1;
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_back_to_back();
    test_reset_mid_count();
    test_reset_level_one();
    total++;
    if (sb.size() !== 0) begin
      bad++;
      $display("[TB] FAIL scoreboard_leftover: saw %0d entries need 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
